// File: rtl/adder_arb_pkg.sv
// Shared defaults and round-robin helpers for the adder arbiter.
package adder_arb_pkg;
    localparam int RES_DEF   = 4;
    localparam int NREQ_DEF  = 4;
    localparam int NREQ_MAX  = 32;
    localparam int NREQ_MAXW = 5;

    typedef logic [NREQ_MAX-1:0] req_vec_t;

    // One-hot grant of the first valid bit at or after ptr, wrapping at nreq.
    function automatic req_vec_t rr_pick(input req_vec_t valid, input int nreq, input int ptr);
        req_vec_t grant;
        int       idx;
        grant = '0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            if (k < nreq && grant == '0) begin
                idx = ptr + k;
                if (idx >= nreq) idx = idx - nreq;
                if (valid[idx[NREQ_MAXW-1:0]]) grant[idx[NREQ_MAXW-1:0]] = 1'b1;
            end
        end
        return grant;
    endfunction

    function automatic int onehot2idx(input req_vec_t oh);
        int idx;
        idx = 0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            if (oh[k]) idx = idx | k;
        end
        return idx;
    endfunction
endpackage

// File: rtl/adder.sv
// Plain RES-bit adder with carry-in; the sum keeps the carry-out as its MSB.
module adder #(
    parameter int RES = 4
) (
    input  logic [RES-1:0] a,
    input  logic [RES-1:0] b,
    input  logic           cin,
    output logic [RES:0]   sum
);
    assign sum = {1'b0, a} + {1'b0, b} + {{RES{1'b0}}, cin};
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one adder among NREQ requesters, registered tagged response.
// state | meaning
// EMPTY | rsp_valid=0, output register free
// FULL  | rsp_valid=1, result waiting for rsp_ready
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int RES  = RES_DEF,
    parameter int NREQ = NREQ_DEF,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0][RES-1:0] req_a,
    input  logic [NREQ-1:0][RES-1:0] req_b,
    input  logic [NREQ-1:0]          req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RES:0]             rsp_sum,
    output logic [IDW-1:0]           rsp_id
);
    logic [IDW-1:0] ptr;
    req_vec_t       pick;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] gidx;
    logic           any_grant;
    logic           accept;
    logic [RES-1:0] op_a;
    logic [RES-1:0] op_b;
    logic           op_cin;
    logic [RES:0]   sum;

    assign pick      = rr_pick(req_vec_t'(req_valid), NREQ, int'(ptr));
    assign grant     = pick[NREQ-1:0];
    assign gidx      = IDW'(onehot2idx(pick));
    assign any_grant = |grant;
    assign accept    = !rsp_valid || rsp_ready;
    // Nothing is offered during reset so no handshake can be lost to it.
    assign req_ready = (rst_n && accept) ? grant : '0;

    assign op_a   = req_a[gidx];
    assign op_b   = req_b[gidx];
    assign op_cin = req_cin[gidx];

    adder #(.RES(RES)) u_adder (
        .a   (op_a),
        .b   (op_b),
        .cin (op_cin),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (accept) begin
            if (any_grant) begin
                rsp_valid <= 1'b1;
                rsp_sum   <= sum;
                rsp_id    <= gidx;
                if (gidx == IDW'(NREQ - 1)) ptr <= '0;
                else                        ptr <= gidx + IDW'(1);
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed table, reset corner sequence and randomized scoreboard run for adder_arbiter.
module tb_adder_arbiter;
    localparam int RES  = 4;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0][RES-1:0] req_a;
    logic [NREQ-1:0][RES-1:0] req_b;
    logic [NREQ-1:0]          req_cin;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [RES:0]             rsp_sum;
    logic [IDW-1:0]           rsp_id;

    int checks = 0;
    int errors = 0;

    adder_arbiter #(.RES(RES), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] valid;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       rr;
        logic [3:0] exp_ready;
        logic       exp_v;
        logic [4:0] exp_sum;
        logic [1:0] exp_id;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [3:0] valid, logic [3:0] a, logic [3:0] b,
                                logic cin, logic rr, logic [3:0] er, logic ev,
                                logic [4:0] es, logic [1:0] ei);
        vec_t v;
        v.rst = rst; v.valid = valid; v.a = a; v.b = b; v.cin = cin; v.rr = rr;
        v.exp_ready = er; v.exp_v = ev; v.exp_sum = es; v.exp_id = ei;
        return v;
    endfunction

    task automatic drive_bcast(bit rst, logic [3:0] valid, logic [3:0] a, logic [3:0] b,
                               logic cin, logic rr);
        rst_n     = !rst;
        req_valid = valid;
        req_a     = {NREQ{a}};
        req_b     = {NREQ{b}};
        req_cin   = {NREQ{cin}};
        rsp_ready = rr;
    endtask

    // Random-phase reference state: pending requests and queued results.
    logic [NREQ-1:0] rv;
    logic [RES-1:0]  ra [NREQ];
    logic [RES-1:0]  rb [NREQ];
    logic            rc [NREQ];
    int              wait_cnt [NREQ];
    int              exp_q[$];
    int              m_ptr;
    bit              m_full;

    initial begin
        int g;
        bit acc;
        logic [3:0] exp_rdy;

        drive_bcast(1'b1, 4'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // rst valid a    b    c  rr   ready    v  sum    id
        tbl.push_back(mk(1, 4'b0000, 4'h0, 4'h0, 0, 1, 4'b0000, 0, 5'h00, 2'd0));
        tbl.push_back(mk(0, 4'b0010, 4'hF, 4'hF, 1, 1, 4'b0010, 1, 5'h1F, 2'd1));
        tbl.push_back(mk(1, 4'b1111, 4'h0, 4'h0, 0, 1, 4'b0000, 0, 5'h00, 2'd0));
        tbl.push_back(mk(0, 4'b1111, 4'h3, 4'h4, 0, 1, 4'b0001, 1, 5'h07, 2'd0));
        tbl.push_back(mk(0, 4'b1111, 4'h3, 4'h4, 0, 1, 4'b0010, 1, 5'h07, 2'd1));
        tbl.push_back(mk(0, 4'b1111, 4'h3, 4'h4, 0, 1, 4'b0100, 1, 5'h07, 2'd2));
        tbl.push_back(mk(0, 4'b1111, 4'h3, 4'h4, 0, 1, 4'b1000, 1, 5'h07, 2'd3));
        tbl.push_back(mk(0, 4'b1111, 4'h3, 4'h4, 0, 1, 4'b0001, 1, 5'h07, 2'd0));
        tbl.push_back(mk(0, 4'b1111, 4'h3, 4'h4, 0, 1, 4'b0010, 1, 5'h07, 2'd1));
        tbl.push_back(mk(0, 4'b1111, 4'h3, 4'h4, 0, 1, 4'b0100, 1, 5'h07, 2'd2));
        tbl.push_back(mk(0, 4'b1111, 4'h3, 4'h4, 0, 1, 4'b1000, 1, 5'h07, 2'd3));
        tbl.push_back(mk(0, 4'b0101, 4'h2, 4'h3, 1, 1, 4'b0001, 1, 5'h06, 2'd0));
        tbl.push_back(mk(0, 4'b0101, 4'h2, 4'h3, 1, 1, 4'b0100, 1, 5'h06, 2'd2));
        tbl.push_back(mk(0, 4'b0100, 4'h2, 4'h3, 1, 1, 4'b0100, 1, 5'h06, 2'd2));
        tbl.push_back(mk(0, 4'b0100, 4'h2, 4'h3, 1, 1, 4'b0100, 1, 5'h06, 2'd2));
        tbl.push_back(mk(0, 4'b1111, 4'h3, 4'h4, 0, 1, 4'b1000, 1, 5'h07, 2'd3));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 4'b1111, 4'h9, 4'h9, 1, 0, 4'b0000, 1, 5'h07, 2'd3));
        tbl.push_back(mk(0, 4'b1111, 4'h1, 4'h1, 0, 1, 4'b0001, 1, 5'h02, 2'd0));
        tbl.push_back(mk(0, 4'b0000, 4'h1, 4'h1, 0, 1, 4'b0000, 0, 5'h02, 2'd0));

        foreach (tbl[r]) begin
            drive_bcast(tbl[r].rst, tbl[r].valid, tbl[r].a, tbl[r].b, tbl[r].cin, tbl[r].rr);
            #1;
            chk($sformatf("row%0d req_ready", r), int'(req_ready), int'(tbl[r].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d rsp_valid", r), int'(rsp_valid), int'(tbl[r].exp_v));
            chk($sformatf("row%0d rsp_sum", r), int'(rsp_sum), int'(tbl[r].exp_sum));
            chk($sformatf("row%0d rsp_id", r), int'(rsp_id), int'(tbl[r].exp_id));
        end

        // Handshake, then reset on the following edge with a request pending.
        drive_bcast(0, 4'b0001, 4'h5, 4'h6, 0, 1);
        #1; chk("rst_seq ready0", int'(req_ready), 4'b0001);
        @(posedge clk); #1;
        chk("rst_seq sum0", int'(rsp_sum), 5'h0B);
        chk("rst_seq id0", int'(rsp_id), 0);
        drive_bcast(1, 4'b0010, 4'h5, 4'h6, 0, 1);
        #1; chk("rst_seq ready_in_rst", int'(req_ready), 0);
        @(posedge clk); #1;
        chk("rst_seq valid_rst", int'(rsp_valid), 0);
        chk("rst_seq sum_rst", int'(rsp_sum), 0);
        chk("rst_seq id_rst", int'(rsp_id), 0);
        drive_bcast(0, 4'b1111, 4'h5, 4'h6, 0, 1);
        #1; chk("rst_seq ptr_zero", int'(req_ready), 4'b0001);
        @(posedge clk); #1;
        chk("rst_seq id_after", int'(rsp_id), 0);
        drive_bcast(0, 4'b1000, 4'h5, 4'h6, 0, 1);
        #1; chk("rst_seq ready3", int'(req_ready), 4'b1000);
        @(posedge clk); #1;
        chk("rst_seq valid3", int'(rsp_valid), 1);
        chk("rst_seq id3", int'(rsp_id), 3);

        // Randomized run against the queue-based reference.
        drive_bcast(1, 4'b0, 4'h0, 4'h0, 0, 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        rv     = '0;
        m_ptr  = 0;
        m_full = 0;
        for (int i = 0; i < NREQ; i++) begin
            wait_cnt[i] = 0; ra[i] = '0; rb[i] = '0; rc[i] = 0;
        end

        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i] && $urandom_range(0, 99) < 40) begin
                    rv[i] = 1'b1;
                    ra[i] = RES'($urandom);
                    rb[i] = RES'($urandom);
                    rc[i] = 1'($urandom);
                end
                req_a[i]   = ra[i];
                req_b[i]   = rb[i];
                req_cin[i] = rc[i];
            end
            req_valid = rv;
            rsp_ready = ($urandom_range(0, 99) < 70);
            #1;

            chk("rand rsp_valid", int'(rsp_valid), int'(m_full));
            if (rsp_valid && exp_q.size() > 0) begin
                chk("rand rsp_sum", int'(rsp_sum), exp_q[0] & 32'h1F);
                chk("rand rsp_id", int'(rsp_id), exp_q[0] >> 8);
            end
            if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());

            acc = !m_full || rsp_ready;
            g = -1;
            if (acc) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && rv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("rand req_ready", int'(req_ready), int'(exp_rdy));

            if (acc) begin
                for (int i = 0; i < NREQ; i++) if (rv[i]) wait_cnt[i]++;
            end
            if (g >= 0) begin
                chk("rand starvation", int'(wait_cnt[g] <= NREQ), 1);
                wait_cnt[g] = 0;
                exp_q.push_back((g << 8) | (int'(ra[g]) + int'(rb[g]) + int'(rc[g])));
                rv[g]  = 1'b0;
                m_ptr  = (g + 1) % NREQ;
                m_full = 1;
            end else if (acc) begin
                m_full = 0;
            end

            @(posedge clk);
            #1;
        end
        chk("rand outstanding", exp_q.size(), int'(rsp_valid));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
